vdp_super_scanner: RTL and testbench

VDP_SUPER_SCANNER -- requirements
Module: vdp_super_scanner

---
 rtl/vdp_super_scanner_pkg.sv | 50 +++++
 rtl/vdp_super_scanner_fifo.sv | 52 +++++
 rtl/vdp_super_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_vdp_super_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_super_scanner_pkg.sv
// Shared types and helpers for the super-resolution scanline fetcher.
package custom_timings;

  typedef enum logic [1:0] {
    BPP8     = 2'd0,
    BPP4     = 2'd1,
    BPP2     = 2'd2,
    BPP_RSVD = 2'd3
  } bpp_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_ACTIVE = 2'd2,
    S_REPLAY = 2'd3
  } state_e;

  localparam int unsigned WORD_BITS = 32;

  function automatic int unsigned bits_per_pixel(input bpp_mode_e bpp);
    case (bpp)
      BPP4:    return 4;
      BPP2:    return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned words_per_line(input bpp_mode_e bpp, input int unsigned pixels);
    return (pixels * bits_per_pixel(bpp) + WORD_BITS - 1) / WORD_BITS;
  endfunction

  function automatic logic [3:0] last_slot(input bpp_mode_e bpp);
    case (bpp)
      BPP4:    return 4'd7;
      BPP2:    return 4'd15;
      default: return 4'd3;
    endcase
  endfunction

  // Pixels are packed LSB-first; narrow modes are zero-extended to a palette index.
  function automatic logic [7:0] unpack_pixel(input logic [31:0] word, input bpp_mode_e bpp,
                                              input logic [3:0] slot);
    case (bpp)
      BPP4:    return 8'((word >> {slot[2:0], 2'b00}) & 32'h0000_000F);
      BPP2:    return 8'((word >> {slot, 1'b0}) & 32'h0000_0003);
      default: return 8'(word >> {slot[1:0], 3'b000});
    endcase
  endfunction

endpackage

// File: rtl/vdp_super_scanner_fifo.sv
// Prefetch word FIFO; simultaneous push and pop on a full FIFO both take effect.
module vdp_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vdp_super_scanner.sv
// Super-resolution scanline fetcher: VRAM prefetch, LSB-first pixel unpack,
// horizontal pixel doubling and odd-line replay from a one-line buffer.
module vdp_super_scanner
  import custom_timings::*;
#(
  parameter int unsigned LINE_PIXELS = 360,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  pixel_en,
  input  logic [1:0]            bpp_mode,
  input  logic                  h_scale,
  input  logic                  v_double,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  disp_on,
  output logic                  vram_req,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic                  vram_ack,
  input  logic [31:0]           vram_data,
  output logic [7:0]            palette_addr,
  output logic                  palette_valid,
  output logic                  underrun
);

  localparam int unsigned PIX_W = $clog2(LINE_PIXELS + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  // state    | meaning
  // IDLE     | waiting for frame_start
  // PRIME    | prefetching the first line before it becomes visible
  // ACTIVE   | fetch line: pixels from the FIFO, copied into the line buffer
  // REPLAY   | replay line: pixels from the line buffer, no VRAM traffic
  state_e                state_q;
  bpp_mode_e             bpp_q, norm_bpp;
  logic                  h_scale_q, v_double_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_line_q;
  logic [PIX_W-1:0]      wpl_q, wpl_new, fetched_q, pix_cnt_q;
  logic [3:0]            slot_q;
  logic                  phase_q, started_q, line_odd_q;
  logic [7:0]            skip_q, skip_d, owed;
  logic                  req_q, req_d, underrun_q, pv_q;
  logic [7:0]            pal_q;
  logic [7:0]            line_buf [LINE_PIXELS];

  logic            live, emit, in_line, advance, word_done, underrun_hit, buf_we;
  logic            flush, ack_take, push, pop, issue_ok, new_issue;
  logic [CW-1:0]   fifo_cnt, cnt_next;
  logic            fifo_empty;
  logic [31:0]     fifo_head;
  logic [7:0]      src_pix;
  logic [PIX_W-1:0] rd_idx;

  vdp_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (vram_data),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_comb begin
    norm_bpp  = (bpp_mode == 2'd3) ? BPP8 : bpp_mode_e'(bpp_mode);
    wpl_new   = PIX_W'(words_per_line(norm_bpp, LINE_PIXELS));
    live      = (state_q == S_ACTIVE) || (state_q == S_REPLAY);
    flush     = !enable || frame_start || (line_start && live);
    emit      = enable && live && pixel_en && !frame_start && !line_start;
    in_line   = (pix_cnt_q < PIX_W'(LINE_PIXELS));
    advance   = emit && in_line && (!h_scale_q || phase_q);
    word_done = advance && (state_q == S_ACTIVE) && (slot_q == last_slot(bpp_q));
    underrun_hit = emit && in_line && (state_q == S_ACTIVE) && fifo_empty;
    buf_we    = emit && in_line && (state_q == S_ACTIVE);
    rd_idx    = in_line ? pix_cnt_q : '0;

    src_pix = 8'h00;
    if (in_line) begin
      if (state_q == S_REPLAY)  src_pix = line_buf[rd_idx];
      else if (!fifo_empty)     src_pix = unpack_pixel(fifo_head, bpp_q, slot_q);
    end

    // A word whose pixels were all missed is dropped when it finally arrives,
    // keeping the rest of the line aligned to its screen position.
    pop      = word_done && !fifo_empty && !flush;
    owed     = skip_q + 8'(word_done && fifo_empty);
    ack_take = req_q && vram_ack;
    push     = 1'b0;
    skip_d   = owed;
    if (ack_take) begin
      if (owed != 8'd0) skip_d = owed - 8'd1;
      else              push   = !flush;
    end
    cnt_next = fifo_cnt + CW'(push) - CW'(pop);

    issue_ok = enable && !flush && ((state_q == S_PRIME) || (state_q == S_ACTIVE)) &&
               (fetched_q < wpl_q) && (cnt_next < CW'(FIFO_DEPTH));
    new_issue = issue_ok && (!req_q || ack_take);
    if (flush)                  req_d = 1'b0;
    else if (!req_q || ack_take) req_d = issue_ok;
    else                        req_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bpp_q       <= BPP8;
      h_scale_q   <= 1'b0;
      v_double_q  <= 1'b0;
      addr_q      <= '0;
      next_line_q <= '0;
      wpl_q       <= '0;
      fetched_q   <= '0;
      pix_cnt_q   <= '0;
      slot_q      <= '0;
      phase_q     <= 1'b0;
      started_q   <= 1'b0;
      line_odd_q  <= 1'b0;
      skip_q      <= '0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
      pv_q        <= 1'b0;
      pal_q       <= '0;
    end else if (!enable) begin
      state_q     <= S_IDLE;
      bpp_q       <= BPP8;
      h_scale_q   <= 1'b0;
      v_double_q  <= 1'b0;
      addr_q      <= '0;
      next_line_q <= '0;
      wpl_q       <= '0;
      fetched_q   <= '0;
      pix_cnt_q   <= '0;
      slot_q      <= '0;
      phase_q     <= 1'b0;
      started_q   <= 1'b0;
      line_odd_q  <= 1'b0;
      skip_q      <= '0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
      pv_q        <= 1'b0;
      pal_q       <= '0;
    end else begin
      req_q  <= req_d;
      skip_q <= skip_d;
      pv_q   <= emit;
      pal_q  <= (emit && disp_on) ? src_pix : 8'h00;
      if (ack_take)     addr_q    <= addr_q + 1'b1;
      if (new_issue)    fetched_q <= fetched_q + 1'b1;
      if (underrun_hit) underrun_q <= 1'b1;
      if (emit && in_line && h_scale_q) phase_q <= !phase_q;
      if (advance) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
        slot_q    <= (slot_q == last_slot(bpp_q)) ? 4'd0 : slot_q + 4'd1;
      end

      case (state_q)
        S_PRIME: begin
          if (line_start) begin
            started_q  <= 1'b1;
            line_odd_q <= 1'b1;
          end
          if ((started_q || line_start) && (fifo_cnt >= CW'(2))) begin
            state_q   <= S_ACTIVE;
            pix_cnt_q <= '0;
            slot_q    <= '0;
            phase_q   <= 1'b0;
          end
        end
        S_ACTIVE, S_REPLAY: begin
          if (line_start) begin
            state_q    <= (v_double_q && line_odd_q) ? S_REPLAY : S_ACTIVE;
            line_odd_q <= !line_odd_q;
            pix_cnt_q  <= '0;
            slot_q     <= '0;
            phase_q    <= 1'b0;
            skip_q     <= '0;
            if (!(v_double_q && line_odd_q)) begin
              addr_q      <= next_line_q;
              next_line_q <= next_line_q + ADDR_WIDTH'(wpl_q);
              fetched_q   <= '0;
            end
          end
        end
        default: ;
      endcase

      if (frame_start) begin
        state_q     <= S_PRIME;
        bpp_q       <= norm_bpp;
        h_scale_q   <= h_scale;
        v_double_q  <= v_double;
        wpl_q       <= wpl_new;
        addr_q      <= base_addr;
        next_line_q <= base_addr + ADDR_WIDTH'(wpl_new);
        fetched_q   <= '0;
        pix_cnt_q   <= '0;
        slot_q      <= '0;
        phase_q     <= 1'b0;
        started_q   <= 1'b0;
        line_odd_q  <= 1'b0;
        skip_q      <= '0;
        underrun_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf[pix_cnt_q] <= src_pix;
  end

  assign vram_req      = req_q;
  assign vram_addr     = addr_q;
  assign palette_addr  = pal_q;
  assign palette_valid = pv_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_vdp_super_scanner.sv
// Directed bench for vdp_super_scanner with a zero-wait VRAM model.
module tb_vdp_super_scanner;
  import custom_timings::*;

  logic        clk = 1'b0;
  logic        reset, enable, frame_start, line_start, pixel_en;
  logic [1:0]  bpp_mode;
  logic        h_scale, v_double, disp_on;
  logic [16:0] base_addr, vram_addr;
  logic        vram_req, vram_ack;
  logic [31:0] vram_data, word_c;
  logic [7:0]  palette_addr;
  logic        palette_valid, underrun;
  logic        ack_on, const_mode;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int req_cyc = 0;
  int a0, r0, errs, vcnt;
  logic [16:0] ack_log [256];
  logic [7:0]  got   [360];
  logic [7:0]  line0 [360];

  always #5 clk = ~clk;

  assign vram_ack  = vram_req & ack_on;
  assign vram_data = const_mode ? word_c : {4{vram_addr[7:0]}};

  always @(posedge clk) begin
    if (vram_req) req_cyc++;
    if (vram_req && vram_ack) begin
      ack_log[ack_cnt % 256] = vram_addr;
      ack_cnt++;
    end
  end

  vdp_super_scanner #(.LINE_PIXELS(360), .ADDR_WIDTH(17), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .line_start(line_start), .pixel_en(pixel_en), .bpp_mode(bpp_mode),
    .h_scale(h_scale), .v_double(v_double), .base_addr(base_addr), .disp_on(disp_on),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_data(vram_data),
    .palette_addr(palette_addr), .palette_valid(palette_valid), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic pix(input int n);
    vcnt = 0;
    for (int i = 0; i < n; i++) begin
      pixel_en = 1'b1;
      @(negedge clk);
      got[i] = palette_addr;
      if (palette_valid) vcnt++;
    end
    pixel_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; frame_start = 1'b0; line_start = 1'b0; pixel_en = 1'b0;
    bpp_mode = 2'd0; h_scale = 1'b0; v_double = 1'b0; disp_on = 1'b1; base_addr = 17'h00100;
    ack_on = 1'b1; const_mode = 1'b1; word_c = 32'h4433_2211;
    cyc(3);
    chk("rst_req", {31'd0, vram_req}, 32'd0);
    chk("rst_addr", {15'd0, vram_addr}, 32'd0);
    chk("rst_pal", {24'd0, palette_addr}, 32'd0);
    chk("rst_valid", {31'd0, palette_valid}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    reset = 1'b0;
    cyc(2);

    // 8bpp frame, constant word 0x44332211 at base 0x100
    a0 = ack_cnt;
    pulse_fs();
    cyc(1);
    chk("a_first_req", {31'd0, vram_req}, 32'd1);
    chk("a_first_addr", {15'd0, vram_addr}, 32'h100);
    cyc(6);
    pulse_ls();
    cyc(2);
    pix(360);
    chk("a_p0", {24'd0, got[0]}, 32'h11);
    chk("a_p1", {24'd0, got[1]}, 32'h22);
    chk("a_p2", {24'd0, got[2]}, 32'h33);
    chk("a_p3", {24'd0, got[3]}, 32'h44);
    errs = 0;
    for (int i = 0; i < 360; i++)
      if (got[i] !== 8'((i % 4 + 1) * 8'h11)) errs++;
    chk("a_line0_errs", errs, 0);
    chk("a_line0_valid", vcnt, 360);
    chk("a_no_underrun", {31'd0, underrun}, 32'd0);
    cyc(2);
    chk("a_words_fetched", ack_cnt - a0, 90);
    pix(1);
    chk("a_past_end", {24'd0, got[0]}, 32'd0);
    chk("a_past_end_valid", vcnt, 1);
    cyc(1);
    chk("a_valid_drop", {31'd0, palette_valid}, 32'd0);

    // line 1: address continues after 90 words; blanked output keeps fetching
    pulse_ls();
    chk("a_line1_addr", {15'd0, vram_addr}, 32'h15A);
    disp_on = 1'b0;
    cyc(6);
    pix(8);
    errs = 0;
    for (int i = 0; i < 8; i++) if (got[i] !== 8'h00) errs++;
    chk("a_blank_errs", errs, 0);
    chk("a_blank_valid", vcnt, 8);
    disp_on = 1'b1;
    pix(4);
    chk("a_unblank0", {24'd0, got[0]}, 32'h11);
    chk("a_unblank3", {24'd0, got[3]}, 32'h44);

    // line_start mid-line: restart at line 2 address
    pulse_ls();
    chk("a_midline_addr", {15'd0, vram_addr}, 32'h1B4);
    cyc(6);
    pix(2);
    chk("a_midline_p0", {24'd0, got[0]}, 32'h11);
    chk("a_midline_p1", {24'd0, got[1]}, 32'h22);

    // 4bpp with horizontal doubling
    bpp_mode = 2'd1; h_scale = 1'b1; word_c = 32'h8765_4321;
    pulse_fs();
    cyc(6);
    pulse_ls();
    cyc(2);
    a0 = ack_cnt;
    pix(64);
    cyc(3);
    chk("b_p0", {24'd0, got[0]}, 32'd1);
    chk("b_p1", {24'd0, got[1]}, 32'd1);
    chk("b_p2", {24'd0, got[2]}, 32'd2);
    chk("b_p15", {24'd0, got[15]}, 32'd8);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (got[i] !== 8'((i / 2) % 8 + 1)) errs++;
    chk("b_seq_errs", errs, 0);
    chk("b_pops", ack_cnt - a0, 4);

    // address wrap at the top of VRAM
    bpp_mode = 2'd0; h_scale = 1'b0; base_addr = 17'h1FFFE;
    a0 = ack_cnt;
    pulse_fs();
    cyc(8);
    chk("c_nacks", ack_cnt - a0, 4);
    chk("c_addr0", {15'd0, ack_log[(a0 + 0) % 256]}, 32'h1FFFE);
    chk("c_addr1", {15'd0, ack_log[(a0 + 1) % 256]}, 32'h1FFFF);
    chk("c_addr2", {15'd0, ack_log[(a0 + 2) % 256]}, 32'h00000);

    // vertical doubling: line 1 replays line 0 with no VRAM traffic
    const_mode = 1'b0; v_double = 1'b1; base_addr = 17'h00200;
    pulse_fs();
    cyc(6);
    pulse_ls();
    cyc(2);
    pix(360);
    errs = 0;
    for (int i = 0; i < 360; i++) begin
      line0[i] = got[i];
      if (got[i] !== 8'(i / 4)) errs++;
    end
    chk("d_line0_errs", errs, 0);
    cyc(2);
    pulse_ls();
    r0 = req_cyc;
    cyc(4);
    pix(360);
    cyc(2);
    errs = 0;
    for (int i = 0; i < 360; i++) if (got[i] !== line0[i]) errs++;
    chk("d_replay_errs", errs, 0);
    chk("d_replay_p100", {24'd0, got[100]}, 32'd25);
    chk("d_replay_reqs", req_cyc - r0, 0);
    pulse_ls();
    chk("d_line2_addr", {15'd0, vram_addr}, 32'h25A);

    // withheld acks during ACTIVE
    const_mode = 1'b1; v_double = 1'b0; base_addr = 17'h00000; word_c = 32'h4433_2211;
    pulse_fs();
    cyc(6);
    pulse_ls();
    cyc(2);
    pix(8);
    cyc(3);
    chk("e_pre_underrun", {31'd0, underrun}, 32'd0);
    ack_on = 1'b0;
    pix(40);
    chk("e_p15", {24'd0, got[15]}, 32'h44);
    chk("e_p16", {24'd0, got[16]}, 32'h00);
    errs = 0;
    for (int i = 0; i < 40; i++)
      if (got[i] !== ((i < 16) ? 8'((i % 4 + 1) * 8'h11) : 8'h00)) errs++;
    chk("e_window_errs", errs, 0);
    chk("e_underrun_set", {31'd0, underrun}, 32'd1);
    ack_on = 1'b1;
    pulse_ls();
    cyc(2);
    chk("e_underrun_sticky", {31'd0, underrun}, 32'd1);
    pulse_fs();
    chk("e_underrun_clear", {31'd0, underrun}, 32'd0);

    // enable low clears to idle
    cyc(2);
    enable = 1'b0;
    cyc(1);
    chk("f_dis_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    chk("f_dis_req", {31'd0, vram_req}, 32'd0);
    enable = 1'b1;

    // reset mid-line with a pending request
    pulse_fs();
    cyc(6);
    pulse_ls();
    cyc(2);
    ack_on = 1'b0;
    pix(20);
    cyc(1);
    chk("g_req_pending", {31'd0, vram_req}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("g_req_async", {31'd0, vram_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("g_req_edge", {31'd0, vram_req}, 32'd0);
    chk("g_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    chk("g_pal", {24'd0, palette_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ack_on = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
